// File: rtl/stream_mux_rr.sv
// N-channel stream multiplexer with a single registered output slot.
// Grants come either from a direct channel select or from a round-robin search.
module stream_mux_rr #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int IDX_W = SEL_W + 1;
  localparam int PAD_N = 1 << SEL_W;

  logic [WIDTH-1:0] word [N_CH];

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign word[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_ch_q,    out_ch_d;
  logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

  logic [PAD_N-1:0] valid_pad;
  logic             cand_valid;
  logic [SEL_W-1:0] cand;
  logic [IDX_W-1:0] idx;
  logic             load_en;
  logic             xfer;

  // valid_pad is zero above N_CH-1, so an out-of-range sel never yields a candidate.
  always_comb begin
    valid_pad             = '0;
    valid_pad[N_CH-1:0]   = in_valid;
    cand_valid            = 1'b0;
    cand                  = '0;
    idx                   = '0;
    if (!mode) begin
      cand_valid = valid_pad[sel];
      cand       = sel;
    end else begin
      // Descending scan: the last hit written is the nearest one after rr_ptr.
      for (int k = N_CH - 1; k >= 0; k--) begin
        idx = {1'b0, rr_ptr_q} + IDX_W'(k);
        if (idx >= IDX_W'(N_CH)) begin
          idx = idx - IDX_W'(N_CH);
        end
        if (valid_pad[idx[SEL_W-1:0]]) begin
          cand_valid = 1'b1;
          cand       = idx[SEL_W-1:0];
        end
      end
    end
  end

  assign load_en = !out_valid_q || out_ready;
  assign xfer    = load_en && cand_valid;

  always_comb begin
    in_ready = '0;
    if (xfer && !rst) begin
      in_ready[cand] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      if (cand_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = word[cand];
        out_ch_d    = cand;
        if (mode) begin
          rr_ptr_d = (cand == SEL_W'(N_CH - 1)) ? '0 : cand + SEL_W'(1);
        end
      end else begin
        out_valid_d = 1'b0;
        out_data_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed scenarios plus random traffic against a
// transaction-level reference model (4 channels), and a 3-channel wrap check.
module tb_stream_mux_rr;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic [1:0]     sel;
  logic           mode;
  logic [W-1:0]   out_data;
  logic [1:0]     out_ch;
  logic           out_valid, out_ready;

  logic [23:0]    in_data3;
  logic [2:0]     in_valid3, in_ready3;
  logic [1:0]     sel3;
  logic           mode3;
  logic [7:0]     out_data3;
  logic [1:0]     out_ch3;
  logic           out_valid3, out_ready3;

  stream_mux_rr #(.N_CH(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_mux_rr #(.N_CH(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .mode(mode3), .out_data(out_data3),
    .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the word held downstream and the round-robin start point.
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_ch;
  int           m_rr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_cand(input logic [3:0] v, input logic [1:0] s,
                                  input logic md, input int rr);
    if (!md) return v[s] ? int'(s) : -1;
    for (int k = 0; k < N; k++) begin
      if (v[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_data  = '0;
    m_ch    = 0;
    m_rr    = 0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle(input string tag);
    int         c;
    bit         ld;
    logic [3:0] exp_rdy;
    #1;
    ld      = !m_valid || out_ready;
    c       = ref_cand(in_valid, sel, mode, m_rr);
    exp_rdy = (ld && c >= 0) ? 4'(1 << c) : 4'b0000;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (ld) begin
      if (c >= 0) begin
        m_valid = 1;
        m_data  = in_data[c*W +: W];
        m_ch    = c;
        if (mode) m_rr = (c + 1) % N;
      end else begin
        m_valid = 0;
        m_data  = '0;
      end
    end
    #1;
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ".out_data"}, 64'(out_data), 64'(m_data));
    if (m_valid) chk({tag, ".out_ch"}, 64'(out_ch), 64'(m_ch));
    if (ld && c >= 0) $display("[TB] %s: accepted ch=%0d data=%h", tag, c, m_data);
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    in_data    = 32'hDEADBEEF;
    in_valid   = 4'hF;
    sel        = 2'd0;
    mode       = 1'b1;
    out_ready  = 1'b1;
    in_data3   = {8'h33, 8'h22, 8'h11};
    in_valid3  = 3'b111;
    sel3       = 2'd0;
    mode3      = 1'b1;
    out_ready3 = 1'b1;
    model_reset();

    #7;
    chk("reset.out_valid", 64'(out_valid), 64'(0));
    chk("reset.out_data", 64'(out_data), 64'(0));
    chk("reset.out_ch", 64'(out_ch), 64'(0));
    chk("reset.in_ready", 64'(in_ready), 64'(0));
    chk("reset.in_ready3", 64'(in_ready3), 64'(0));
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = '0;
    in_valid3 = '0;

    // Direct select of channel 2.
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b0100;
    in_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
    #1 chk("direct.in_ready", 64'(in_ready), 64'(4'b0100));
    cycle("direct");
    chk("direct.word", 64'({out_valid, out_ch, out_data}), 64'({1'b1, 2'd2, 8'hA5}));

    // Round-robin with every channel valid.
    mode     = 1'b1;
    in_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'($urandom);
      cycle("rr_all");
      chk("rr_all.seq", 64'(out_ch), 64'(i % 4));
    end

    // Stall with 8'h3C held.
    mode     = 1'b0;
    sel      = 2'd0;
    in_valid = 4'b0001;
    in_data  = {8'h01, 8'h02, 8'h03, 8'h3C};
    cycle("load3c");
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 4'($urandom) | 4'b0001;
      mode     = 1'($urandom);
      sel      = 2'($urandom);
      in_data  = 32'($urandom);
      cycle("stall");
      chk("stall.hold", 64'(out_data), 64'(8'h3C));
      chk("stall.in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    mode      = 1'b0;
    sel       = 2'd1;
    in_valid  = 4'b0010;
    in_data   = {8'h00, 8'h00, 8'h5A, 8'h00};
    cycle("release");
    chk("release.data", 64'(out_data), 64'(8'h5A));

    // Selected channel idle while another is valid.
    in_valid  = 4'b1000;
    out_ready = 1'b0;
    cycle("nocand_held");
    out_ready = 1'b1;
    cycle("nocand_drain");
    chk("nocand.out_valid", 64'(out_valid), 64'(0));
    chk("nocand.out_data", 64'(out_data), 64'(0));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom);
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = 32'($urandom);
      cycle("rand");
    end

    // Three-channel wrap-around.
    in_valid  = '0;
    out_ready = 1'b1;
    in_valid3 = 3'b100;
    #1 chk("wrap3.rdy_a", 64'(in_ready3), 64'(3'b100));
    cycle("idle4");
    chk("wrap3.ch_a", 64'({out_valid3, out_ch3, out_data3}), 64'({1'b1, 2'd2, 8'h33}));
    in_valid3 = 3'b101;
    #1 chk("wrap3.rdy_b", 64'(in_ready3), 64'(3'b001));
    cycle("idle4");
    chk("wrap3.ch_b", 64'({out_valid3, out_ch3, out_data3}), 64'({1'b1, 2'd0, 8'h11}));
    #1 chk("wrap3.rdy_c", 64'(in_ready3), 64'(3'b100));
    cycle("idle4");
    chk("wrap3.ch_c", 64'(out_ch3), 64'(2));
    in_valid3 = '0;

    // Reset while a stalled word is held.
    mode     = 1'b1;
    in_valid = 4'hF;
    in_data  = 32'hC0FFEE11;
    cycle("pre_rst");
    out_ready = 1'b0;
    cycle("pre_rst_stall");
    #2 rst = 1'b1;
    #1;
    chk("async_rst.out_valid", 64'(out_valid), 64'(0));
    chk("async_rst.out_data", 64'(out_data), 64'(0));
    chk("async_rst.out_ch", 64'(out_ch), 64'(0));
    chk("async_rst.in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    out_ready = 1'b1;
    cycle("post_rst");
    chk("post_rst.ch0", 64'(out_ch), 64'(0));
    cycle("post_rst");
    chk("post_rst.ch1", 64'(out_ch), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning number of input channels (legal 2..16).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning data bits per channel (legal 1..64).
REQ-003 The block SHALL use localparam SEL_W = max(1, clog2(N_CH)), meaning channel-index width.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_data  input  N_CH*WIDTH  flattened channel data; channel i at bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N_CH  bit i high = channel i offers a word.
REQ-008 in_ready  output  N_CH  bit i high = channel i word accepted this cycle if valid.
REQ-009 sel  input  SEL_W  channel index used in direct mode.
REQ-010 mode  input  1  0 = direct select by sel; 1 = round-robin arbitration.
REQ-011 out_data  output  WIDTH  registered selected word.
REQ-012 out_ch  output  SEL_W  index of the channel that produced out_data.
REQ-013 out_valid  output  1  out_data/out_ch hold a word.
REQ-014 out_ready  input  1  downstream accepts the word when out_valid also high.

Function
REQ-015 The block SHALL hold one word in an output register; load_en = !out_valid || out_ready.
REQ-016 Direct mode: candidate = sel if sel < N_CH and in_valid[sel]; otherwise no candidate.
REQ-017 Round-robin mode: candidate = first channel with in_valid high, searching rr_ptr, rr_ptr+1, ... N_CH-1, wrapping to 0; none if in_valid all zero.
REQ-018 in_ready SHALL be one-hot or zero: only bit [candidate] may be high, and only when load_en is high; in_ready SHALL depend combinationally on in_valid, sel, mode, rr_ptr, out_valid and out_ready.
REQ-019 On a transfer (in_valid[c] && in_ready[c]), the next edge SHALL load out_data = word c, out_ch = c, out_valid = 1.
REQ-020 If load_en is high and there is no candidate, the next edge SHALL set out_valid = 0 and out_data = 0.
REQ-021 out_data SHALL be all-zero whenever out_valid is 0.
REQ-022 While out_valid && !out_ready, out_data and out_ch SHALL be held unchanged and all in_ready bits SHALL be 0.
REQ-023 Latency SHALL be exactly 1 cycle from input transfer to out_valid; sustained throughput SHALL be 1 word/cycle when out_ready is held high.
REQ-024 rr_ptr (SEL_W bits) SHALL advance to (c+1) mod N_CH on every round-robin-mode transfer and SHALL be unchanged otherwise (including all direct-mode transfers).
REQ-025 Wrap-around: when c = N_CH-1, rr_ptr SHALL become 0, including when N_CH is not a power of two.
REQ-026 A change of mode or sel SHALL affect only the next grant; a held word SHALL not be altered.
REQ-027 Accepted words SHALL never be dropped or duplicated; at most one word is accepted per cycle.

Reset
REQ-028 While rst is high: out_valid = 0, out_data = 0, out_ch = 0, rr_ptr = 0, in_ready = 0, all asynchronously.
REQ-029 Asserting rst mid-operation SHALL discard the held word; normal operation SHALL resume on the first rising edge after rst deasserts.

Verification
REQ-030 Direct mode, N_CH=4, WIDTH=8, sel=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_ch=2.
REQ-031 Round-robin, all four valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, one word per cycle.
REQ-032 Stall: out_valid=1 with out_data=8'h3C, out_ready=0 for 5 cycles -> out_data stays 8'h3C, in_ready=0 every cycle; first cycle out_ready=1 -> next word loads.
REQ-033 Direct mode, sel=1, in_valid=4'b1000 -> in_ready=0; once out_ready=1 drains the held word, out_valid=0 and out_data=0.
REQ-034 N_CH=3, round-robin, only ch2 valid -> accepted, rr_ptr wraps to 0; then ch0 and ch2 valid -> ch0 granted first.
REQ-035 rst pulsed while out_valid=1 and stalled -> out_valid, out_data, out_ch drop to 0 immediately without a clock edge; after release, round-robin grant restarts from ch0.
